// File: rtl/alu_pkg.sv
// Shared op encoding and state type for the ALU controller and execute stage.
package alu_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_SHAMT_W    = 5;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_SUB = 4'b0001,
    OP_ADD = 4'b0010,
    OP_OR  = 4'b0011,
    OP_XOR = 4'b0100,
    OP_SLL = 4'b0101,
    OP_SRL = 4'b0110,
    OP_SRA = 4'b0111,
    OP_EQ  = 4'b1000,
    OP_SLT = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction
endpackage

// File: rtl/alu_shift_iter.sv
// One-bit-per-cycle shifter; o_done flags the cycle whose shift is the last one.
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SHAMT_W    = DEF_SHAMT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_flush,
  input  logic                  i_start,
  input  logic [3:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [SHAMT_W-1:0]    i_shamt,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result
);
  logic [DATA_WIDTH-1:0] r_sh;
  logic [SHAMT_W-1:0]    r_cnt;
  logic                  r_left;
  logic                  r_arith;
  logic [DATA_WIDTH-1:0] w_next;

  assign w_next = r_left ? {r_sh[DATA_WIDTH-2:0], 1'b0}
                         : {r_arith & r_sh[DATA_WIDTH-1], r_sh[DATA_WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh    <= '0;
      r_cnt   <= '0;
      r_left  <= 1'b0;
      r_arith <= 1'b0;
    end else if (i_flush) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_sh    <= i_a;
      r_cnt   <= i_shamt;
      r_left  <= (i_op == OP_SLL);
      r_arith <= (i_op == OP_SRA);
    end else if (o_busy) begin
      r_sh  <= w_next;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_busy   = (r_cnt != '0);
  assign o_done   = (r_cnt == SHAMT_W'(1));
  assign o_result = w_next;
endmodule

// File: rtl/alu_exec_unit.sv
// Registered execute stage: single-cycle logic/arith/compare, iterative shifts.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SHAMT_W    = DEF_SHAMT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_zero
);
  alu_state_e            r_state;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_zero;

  logic [SHAMT_W-1:0]    w_shamt;
  logic                  w_accept;
  logic                  w_sh_start;
  logic                  w_sh_busy;
  logic                  w_sh_done;
  logic [DATA_WIDTH-1:0] w_sh_res;
  logic [DATA_WIDTH-1:0] w_alu_res;

  assign w_shamt    = in_b[SHAMT_W-1:0];
  assign in_ready   = ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready))
                      && !flush && !w_sh_busy;
  assign w_accept   = in_valid && in_ready;
  assign w_sh_start = w_accept && is_shift_op(in_op) && (w_shamt != '0);

  // Shift ops only reach this path with shamt 0, where the result is a unchanged.
  always_comb begin
    w_alu_res = '0;
    case (in_op)
      OP_AND:  w_alu_res = in_a & in_b;
      OP_SUB:  w_alu_res = in_a - in_b;
      OP_ADD:  w_alu_res = in_a + in_b;
      OP_OR:   w_alu_res = in_a | in_b;
      OP_XOR:  w_alu_res = in_a ^ in_b;
      OP_SLL, OP_SRL, OP_SRA: w_alu_res = in_a;
      OP_EQ:   w_alu_res = {{(DATA_WIDTH-1){1'b0}}, in_a == in_b};
      OP_SLT:  w_alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      default: w_alu_res = '0;
    endcase
  end

  alu_shift_iter #(.DATA_WIDTH(DATA_WIDTH), .SHAMT_W(SHAMT_W)) u_shift (
    .clk      (clk),
    .reset    (reset),
    .i_flush  (flush),
    .i_start  (w_sh_start),
    .i_op     (in_op),
    .i_a      (in_a),
    .i_shamt  (w_shamt),
    .o_busy   (w_sh_busy),
    .o_done   (w_sh_done),
    .o_result (w_sh_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else if (flush) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            if (w_sh_start) begin
              r_state <= ST_SHIFT;
            end else begin
              r_state  <= ST_DONE;
              r_result <= w_alu_res;
              r_zero   <= (w_alu_res == '0);
            end
          end else if ((r_state == ST_DONE) && out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (w_sh_done) begin
            r_state  <= ST_DONE;
            r_result <= w_sh_res;
            r_zero   <= (w_sh_res == '0);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid  = (r_state == ST_DONE);
  assign out_result = r_result;
  assign out_zero   = r_zero;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and random checks of alu_exec_unit against a plain-arithmetic model.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero;

  int n_chk = 0;
  int n_fail = 0;

  alu_exec_unit #(.DATA_WIDTH(32), .SHAMT_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int s;
    logic signed [31:0] sa;
    s  = int'(b[4:0]);
    sa = a;
    case (op)
      4'd0: return a & b;
      4'd1: return a - b;
      4'd2: return a + b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << s;
      4'd6: return a >> s;
      4'd7: return sa >>> s;
      4'd8: return (a == b) ? 32'd1 : 32'd0;
      4'd9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Issue one op, check latency/result, optionally stall the consumer, then drain.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    logic [31:0] e;
    int lat;
    int el;
    bit got;
    e  = ref_alu(op, a, b);
    el = (op >= 4'd5 && op <= 4'd7) ? int'(b[4:0]) : 0;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_op = 4'($urandom);
    lat = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1;
      else begin
        chk("busy_in_ready", in_ready, 0);
        lat++;
      end
    end
    chk("valid_timeout", got, 1);
    chk("latency", lat, el);
    chk("result", out_result, e);
    chk("zero", out_zero, (e == 0));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_result", out_result, e);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("valid_drop", out_valid, 0);
  endtask

  initial begin
    int vcount;
    logic [31:0] ra, rb;
    logic [3:0]  rop;

    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_zero", out_zero, 1);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b0;

    do_op(4'd2, 32'd5, 32'd7, 0);

    // SUB then EQ back-to-back with no bubble
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd1; in_a = 32'd3; in_b = 32'd3;
    @(posedge clk); #1;
    in_op = 4'd8; in_a = 32'd9; in_b = 32'd9; out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_valid0", out_valid, 1);
    chk("b2b_res0", out_result, 0);
    chk("b2b_zero0", out_zero, 1);
    chk("b2b_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid1", out_valid, 1);
    chk("b2b_res1", out_result, 1);
    chk("b2b_zero1", out_zero, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("b2b_drop", out_valid, 0);

    do_op(4'd7, 32'h8000_0000, 32'd4, 0);
    do_op(4'd9, 32'hFFFF_FFFF, 32'd1, 3);

    // Flush on the 10th SHIFT cycle of SLL by 31
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd5; in_a = 32'd1; in_b = 32'd31;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_ready", in_ready, 1);
    vcount = 0;
    for (int i = 0; i < 35; i++) begin
      if (out_valid) vcount++;
      @(negedge clk);
    end
    chk("flush_no_valid", vcount, 0);
    do_op(4'd3, 32'hF0, 32'h0F, 0);

    // Flush discards a held result
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd2; in_a = 32'd1; in_b = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("flushd_valid_pre", out_valid, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flushd_valid", out_valid, 0);
    chk("flushd_ready", in_ready, 1);

    for (int n = 0; n < 50; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = (n % 5 == 0) ? 32'h8000_0000 : $urandom;
      rb  = (n % 7 == 0) ? ra : $urandom;
      if (n % 9 == 0) rb[4:0] = 5'd0;
      do_op(rop, ra, rb, n % 4);
    end

    do_op(4'd3, 32'hF0, 32'h0F, 0);
    // Async reset mid-SRL
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd6; in_a = 32'hDEAD_BEEF; in_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_result", out_result, 0);
    chk("arst_zero", out_zero, 1);
    chk("arst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    do_op(4'hF, $urandom, $urandom, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered execute stage directly downstream of the ALU control decoder. It consumes the 4-bit `Operation` code plus two operands and produces a registered result and zero flag under a valid/ready handshake. Logic, add/sub, compare and equality complete in one cycle. Shifts run iteratively, one bit per cycle, to keep the barrel shifter off the critical path. The result feeds the memory/write-back boundary and the branch decision.

## Interface
- `DATA_WIDTH`, 32: operand/result width.
- `SHAMT_W`, 5: shift-amount bits taken from `in_b[SHAMT_W-1:0]`.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous kill of any in-flight or held operation.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  stage can accept.
- `in_op`  in  4  Operation code from the ALU controller.
- `in_a`, `in_b`  in  DATA_WIDTH  operands (`in_a` = rs1, `in_b` = rs2/imm).
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer accepts result.
- `out_result`  out  DATA_WIDTH  registered result.
- `out_zero`  out  1  `out_result == 0`.

## Operation
- Op codes:
  - 0000 AND; 0001 SUB; 0010 ADD; 0011 OR; 0100 XOR.
  - 0101 SLL; 0110 SRL; 0111 SRA.
  - 1000 EQ: result = 1 if `a==b`, else 0.
  - 1001 SLT: signed, result = 1 if `a<b`, else 0.
  - All other codes: result = 0, one-cycle path.
- Arithmetic is modulo 2^DATA_WIDTH; carry and overflow are dropped. SRA replicates the MSB; SRL and SLL fill with zero.
- Operands are captured on accept. Later input changes have no effect.
- FSM states:
  - IDLE: `in_ready`=1. On accept of a non-shift op, or a shift with shamt 0, go to DONE. On accept of a shift with shamt>0, go to SHIFT: load the shift register with `a`, load the counter with shamt.
  - SHIFT: `in_ready`=0. Each cycle shift one bit and decrement the counter. When the counter reaches 1, apply the final shift and go to DONE.
  - DONE: `out_valid`=1.
    - `out_ready`=1 with no new accept: go to IDLE.
    - `out_ready`=1 with a same-cycle accept: take the next state as from IDLE (back-to-back).
    - `out_ready`=0: hold the result and flags stable.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready), gated low while `flush`=1.
- `flush`: next state is IDLE and `out_valid` drops next cycle. No accept occurs in the flush cycle. `flush` has priority over all handshakes.
- Shift with shamt 0: result = `a`, one-cycle latency.

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_result`=0, `out_zero`=1, `in_ready`=1 (when `flush`=0), counter 0.
- Non-shift op accepted at edge N: `out_valid`=1 after edge N+1.
- Shift by s>0 accepted at edge N: `out_valid`=1 after edge N+1+s. Maximum is 32 cycles busy.
- Throughput: one non-shift op per cycle while `out_ready`=1.
- Reset asserted mid-SHIFT or in DONE aborts immediately; the held result is discarded.
- `out_result` and `out_zero` change only on the entry edge into DONE.

## Structure
- Package `alu_pkg`: `alu_op_e` enum with the ten codes above, `DATA_WIDTH` default, and `alu_state_e` (IDLE, SHIFT, DONE).
- Sub-module `alu_shift_iter`: shift register, down-counter, and direction/arith control, with a `start`/`busy`/`done` interface. The top holds the FSM, single-cycle datapath and output registers.
- Same package shared with the ALU controller for the op encoding.

## Test plan
- Reset, then ADD a=5, b=7 with `out_ready`=1 → `out_result`=12, `out_zero`=0, one cycle after accept.
- SUB a=3, b=3, then EQ a=9, b=9 back-to-back, no bubble → results 0 (zero=1) then 1 (zero=0) on consecutive cycles.
- SRA a=0x80000000, b=4 → `out_valid` 5 cycles after accept, result 0xF8000000; `in_ready`=0 during the 4 SHIFT cycles.
- SLT a=0xFFFFFFFF, b=1 with `out_ready`=0 for 3 cycles → result 1 held stable, `in_ready`=0, then released.
- SLL a=1, b=31 with `flush` raised on the 10th SHIFT cycle → no `out_valid`, IDLE next cycle. A following OR 0xF0|0x0F gives 0xFF.
- Async `reset` pulse mid-SRL → outputs return to reset values before the next clock edge; op code 1111 afterwards → result 0, `out_zero`=1.
